clkmgr_ce_gen: RTL and testbench



---
 rtl/clkmgr_pkg.sv | 20 ++
 rtl/clkmgr_ce_gen_if.sv | 17 +
 rtl/clkmgr_ce_div.sv | 41 ++++
 rtl/clkmgr_ce_gen.sv | 119 +++++++++++
 tb/tb_clkmgr_ce_gen.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkmgr_pkg.sv
// Shared types and helpers for the clock manager.
// Purely declarative; no latency and no backpressure.
// State encoding, channel limit and divide normalisation live here.
package clkmgr_pkg;

    localparam int MAX_OUT = 8;
    localparam int SEL_W   = $clog2(MAX_OUT);

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } clk_state_t;

    // A programmed divide of 0 behaves like 1: enable every cycle.
    function automatic int unsigned eff_div(input int unsigned div);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/clkmgr_ce_gen_if.sv
// Divide-reconfiguration port of the clock manager.
// Handshake completes on an edge with cfg_valid and cfg_ready both high.
// Requester holds fields stable while cfg_ready is low.
interface clkmgr_ce_gen_if
    import clkmgr_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_sel;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (output cfg_valid, cfg_sel, cfg_div, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_sel, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clkmgr_ce_div.sv
// One clock-enable channel: divide register plus reloading down-counter.
// ce is a decode of registered state; a new divide takes effect after clr.
// No backpressure; load and clr are single-cycle strobes from the manager.
module clkmgr_ce_div
    import clkmgr_pkg::*;
#(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] DIV_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             ce
);
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload;

    assign reload = CNT_W'(eff_div(32'(div)) - 32'd1);
    assign ce     = en && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= DIV_RST;
            cnt <= '0;
        end else begin
            if (load) begin
                div <= load_div;
            end
            // Holding at zero outside LOCKED makes every channel fire on the first locked cycle.
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= (cnt == '0) ? reload : cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/clkmgr_ce_gen.sv
// Clock manager: lock sequencing, held-off downstream reset, NUM_OUT divided enables.
// locked after LOCK_CYCLES edges in LOCKING; rst_out_n RST_HOLD edges later.
// cfg held pending while not LOCKED; CLKMGR_LOSS_CNT_EN adds lock_loss_cnt.
module clkmgr_ce_gen
    import clkmgr_pkg::*;
#(
    parameter int                       NUM_OUT     = 2,
    parameter int                       CNT_W       = 8,
    parameter logic [NUM_OUT*CNT_W-1:0] DIV_INIT    = {8'd4, 8'd10},
    parameter int                       LOCK_CYCLES = 64,
    parameter int                       RST_HOLD    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rst,
    input  logic               pwrdwn,
    clkmgr_ce_gen_if.slave     cfg,
    output logic [NUM_OUT-1:0] ce,
    output logic               locked,
    output logic               rst_out_n
`ifdef CLKMGR_LOSS_CNT_EN
    ,
    output logic [7:0]         lock_loss_cnt
`endif
);
    localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int HLD_W = $clog2(RST_HOLD + 1);

    clk_state_t       state;
    clk_state_t       state_nxt;
    logic [LCK_W-1:0] lock_cnt;
    logic [HLD_W-1:0] hold_cnt;
    logic             soft_rst;
    logic             xfer;
    logic             sel_ok;
    logic             cfg_hit;
    logic             cfg_err_q;
    logic             ch_clr;

    assign soft_rst      = rst || pwrdwn;
    assign locked        = (state == LOCKED);
    assign cfg.cfg_ready = locked;
    assign cfg.cfg_err   = cfg_err_q;
    // Manager reset wins over a handshake landing on the same edge.
    assign xfer          = cfg.cfg_valid && locked && !soft_rst;
    assign sel_ok        = ({1'b0, cfg.cfg_sel} < (SEL_W + 1)'(NUM_OUT));
    assign cfg_hit       = xfer && sel_ok;
    assign ch_clr        = (state_nxt != LOCKED);

    always_comb begin
        state_nxt = state;
        if (soft_rst) begin
            state_nxt = RESET;
        end else begin
            case (state)
                RESET:   state_nxt = LOCKING;
                LOCKING: if (lock_cnt == LCK_W'(LOCK_CYCLES - 1)) state_nxt = LOCKED;
                LOCKED:  if (cfg_hit) state_nxt = LOCKING;
                default: state_nxt = RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET;
            lock_cnt  <= '0;
            hold_cnt  <= '0;
            rst_out_n <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_err_q <= xfer && !sel_ok;

            if (state == LOCKING && state_nxt == LOCKING) begin
                lock_cnt <= lock_cnt + LCK_W'(1);
            end else begin
                lock_cnt <= '0;
            end

            // rst_out_n drops on the same edge as locked, rises RST_HOLD edges after it.
            if (state_nxt != LOCKED) begin
                rst_out_n <= 1'b0;
                hold_cnt  <= '0;
            end else if (locked && !rst_out_n) begin
                if (hold_cnt == HLD_W'(RST_HOLD - 1)) begin
                    rst_out_n <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + HLD_W'(1);
                end
            end
        end
    end

`ifdef CLKMGR_LOSS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= 8'd0;
        end else if (locked && soft_rst && lock_loss_cnt != 8'hFF) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
        clkmgr_ce_div #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_div (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (locked),
            .clr      (ch_clr),
            .load     (cfg_hit && (cfg.cfg_sel == SEL_W'(i))),
            .load_div (cfg.cfg_div),
            .ce       (ce[i])
        );
    end
endmodule

// File: tb/tb_clkmgr_ce_gen.sv
// Bench for clkmgr_ce_gen: time-based reference model plus directed scenarios.
module tb_clkmgr_ce_gen;
    localparam int          NUM_OUT = 2;
    localparam int          LOCK_C  = 16;
    localparam int          HOLD_C  = 4;
    localparam logic [15:0] DIV_I   = {8'd10, 8'd4};

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rst = 1'b0;
    logic               pwrdwn = 1'b0;
    logic [NUM_OUT-1:0] ce;
    logic               locked;
    logic               rst_out_n;
    logic [7:0]         loss;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    clkmgr_ce_gen_if #(.CNT_W(8)) cfg_if ();

    clkmgr_ce_gen #(
        .NUM_OUT     (NUM_OUT),
        .CNT_W       (8),
        .DIV_INIT    (DIV_I),
        .LOCK_CYCLES (LOCK_C),
        .RST_HOLD    (HOLD_C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rst       (rst),
        .pwrdwn    (pwrdwn),
        .cfg       (cfg_if),
        .ce        (ce),
        .locked    (locked),
        .rst_out_n (rst_out_n)
`ifdef CLKMGR_LOSS_CNT_EN
        ,
        .lock_loss_cnt (loss)
`endif
    );
`ifndef CLKMGR_LOSS_CNT_EN
    assign loss = 8'd0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: locked is a time interval [m_lock_t, ...); enables are phase offsets from m_lock_t.
    bit m_in_reset = 1'b1;
    int m_lock_t   = -1;
    int m_err_at   = -1;
    int m_loss     = 0;
    int m_div [NUM_OUT];

    initial for (int i = 0; i < NUM_OUT; i++) m_div[i] = int'(DIV_I[i*8 +: 8]);

    function automatic bit m_locked_at(input int c);
        return !m_in_reset && m_lock_t >= 0 && c >= m_lock_t;
    endfunction

    always @(posedge clk) begin
        bit was_locked;
        cyc++;
        was_locked = m_locked_at(cyc - 1);
        if (!rst_n) begin
            m_in_reset = 1'b1;
            m_lock_t   = -1;
            m_err_at   = -1;
            m_loss     = 0;
            for (int i = 0; i < NUM_OUT; i++) m_div[i] = int'(DIV_I[i*8 +: 8]);
        end else if (rst || pwrdwn) begin
            if (was_locked && m_loss < 255) m_loss++;
            m_in_reset = 1'b1;
            m_lock_t   = -1;
        end else if (m_in_reset) begin
            m_in_reset = 1'b0;
            m_lock_t   = cyc + LOCK_C;
        end else if (was_locked && cfg_if.cfg_valid) begin
            if (int'(cfg_if.cfg_sel) < NUM_OUT) begin
                m_div[cfg_if.cfg_sel] = int'(cfg_if.cfg_div);
                m_lock_t = cyc + LOCK_C;
            end else begin
                m_err_at = cyc;
            end
        end
    end

    always @(negedge clk) begin
        bit lk;
        int ce_e;
        int d;
        lk   = m_locked_at(cyc);
        ce_e = 0;
        for (int i = 0; i < NUM_OUT; i++) begin
            d = (m_div[i] == 0) ? 1 : m_div[i];
            if (lk && ((cyc - m_lock_t) % d) == 0) ce_e |= (1 << i);
        end
        chk("m_locked", int'(locked), int'(lk));
        chk("m_cfg_ready", int'(cfg_if.cfg_ready), int'(lk));
        chk("m_rst_out_n", int'(rst_out_n), int'(lk && cyc >= m_lock_t + HOLD_C));
        chk("m_cfg_err", int'(cfg_if.cfg_err), int'(m_err_at == cyc));
        chk("m_ce", int'(ce), ce_e);
`ifdef CLKMGR_LOSS_CNT_EN
        chk("m_loss", int'(loss), m_loss);
`endif
    end

    task automatic wait_lock(output int n);
        n = 0;
        while (!locked && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("align_ce", int'(ce), 3);
    endtask

    task automatic period(input int ch, output int p);
        int k;
        k = 0;
        while (!ce[ch] && k < 200) begin
            @(negedge clk);
            k++;
        end
        p = 0;
        do begin
            @(negedge clk);
            p++;
        end while (!ce[ch] && p < 200);
    endtask

    task automatic do_cfg(input logic [2:0] sel, input logic [7:0] dv, output int waited);
        cfg_if.cfg_sel   = sel;
        cfg_if.cfg_div   = dv;
        cfg_if.cfg_valid = 1'b1;
        waited = 0;
        while (!cfg_if.cfg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int p;
        int w;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_sel   = 3'd0;
        cfg_if.cfg_div   = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_locked", int'(locked), 0);
        chk("rst_ce", int'(ce), 0);
        chk("rst_rst_out_n", int'(rst_out_n), 0);
        chk("rst_cfg_ready", int'(cfg_if.cfg_ready), 0);
        chk("rst_cfg_err", int'(cfg_if.cfg_err), 0);

        rst_n = 1'b1;
        wait_lock(n);
        chk("lock_latency", n, 17);
        n = 0;
        while (!rst_out_n && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hold_latency", n, 4);
        period(0, p); chk("per0_init", p, 4);
        period(1, p); chk("per1_init", p, 10);

        rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_locked", int'(locked), 0);
        chk("rst_drop_ce", int'(ce), 0);
        chk("rst_drop_out_n", int'(rst_out_n), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_lock(n);
        chk("relock_latency", n, 17);
        period(0, p); chk("per0_after_rst", p, 4);
        period(1, p); chk("per1_after_rst", p, 10);

        do_cfg(3'd1, 8'd6, w);
        chk("cfg_no_wait", w, 0);
        chk("cfg_relock_drop", int'(locked), 0);
        wait_lock(n);
        chk("cfg_relock_latency", n, 16);
        period(0, p); chk("per0_cfg6", p, 4);
        period(1, p); chk("per1_cfg6", p, 6);

        do_cfg(3'd5, 8'd9, w);
        chk("bad_sel_err", int'(cfg_if.cfg_err), 1);
        chk("bad_sel_locked", int'(locked), 1);
        @(negedge clk);
        chk("bad_sel_err_once", int'(cfg_if.cfg_err), 0);
        period(1, p); chk("per1_bad_sel", p, 6);

        do_cfg(3'd0, 8'd0, w);
        wait_lock(n);
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (ce[0]) p++;
            @(negedge clk);
        end
        chk("div0_every_cycle", p, 8);

        do_cfg(3'd1, 8'd3, w);
        do_cfg(3'd0, 8'd5, w);
        chk("pending_wait", w, 16);
        chk("pending_relock", int'(locked), 0);
        wait_lock(n);
        period(0, p); chk("per0_pending", p, 5);
        period(1, p); chk("per1_pending", p, 3);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_out_n", int'(rst_out_n), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_lock(n);
        chk("arst_relock", n, 17);
        period(0, p); chk("per0_reload", p, 4);
        period(1, p); chk("per1_reload", p, 10);

        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                cfg_if.cfg_sel   = 3'd1;
                cfg_if.cfg_div   = 8'd2;
                cfg_if.cfg_valid = 1'b1;
            end
            pwrdwn = 1'b1;
            repeat (2) @(negedge clk);
            pwrdwn = 1'b0;
            cfg_if.cfg_valid = 1'b0;
            wait_lock(n);
            chk("pwrdwn_relock", n, 17);
        end
        period(1, p); chk("per1_dropped_cfg", p, 10);
        do_cfg(3'd0, 8'd4, w);
        wait_lock(n);
`ifdef CLKMGR_LOSS_CNT_EN
        chk("loss_cnt", int'(loss), 3);
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
